spectral_scaler: RTL and testbench

SPECTRAL_SCALER -- requirements
Module: spectral_scaler

---
 rtl/spectral_scaler.sv | 164 ++++++++++++++++
 tb/tb_spectral_scaler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectral_scaler.sv
// Spectral pitch scaler: clears the output spectrum, then remaps bin k of the
// selected ping-pong buffer to bin (k*scale)>>8, scaling the phase by the same factor.
module spectral_scaler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go_in,
   input  logic        cur_buf,
   input  logic [11:0] scale,
   output logic [11:0] mag_buf_0_addr,
   input  logic [15:0] mag_buf_0_data,
   output logic [11:0] phase_buf_0_addr,
   input  logic [15:0] phase_buf_0_data,
   output logic [11:0] mag_buf_1_addr,
   input  logic [15:0] mag_buf_1_data,
   output logic [11:0] phase_buf_1_addr,
   input  logic [15:0] phase_buf_1_data,
   output logic [11:0] out_mag_addr,
   output logic [15:0] out_mag_data,
   output logic        out_mag_wren,
   output logic [11:0] out_phase_addr,
   output logic [15:0] out_phase_data,
   output logic        out_phase_wren,
   output logic        busy,
   output logic        go_out
);

   typedef enum logic [2:0] {IDLE, CLEAR, SCAN, DRAIN, DONE} state_t;

   state_t      state, state_nxt;
   logic [10:0] cnt, cnt_nxt;
   logic        sel;
   logic [11:0] scl;

   // Read-side stage: marks the cycle in which RAM data for bin rd_k is valid.
   logic        rd_vld;
   logic [10:0] rd_k;
   logic [15:0] rd_mag, rd_phase;

   // Write-side stage: remapped bin and scaled values ready to drive out.
   logic        wr_vld;
   logic [14:0] wr_j;
   logic [15:0] wr_mag, wr_phase;
   logic        scan_wren;

   assign rd_mag    = sel ? mag_buf_1_data   : mag_buf_0_data;
   assign rd_phase  = sel ? phase_buf_1_data : phase_buf_0_data;
   assign scan_wren = wr_vld && (wr_j[14:11] == 4'd0);

   // State and phase counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic; the 11-bit counter wraps to 0 at the end of CLEAR and SCAN.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (go_in) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            cnt_nxt = cnt + 11'd1;
            if (cnt == 11'd2047) state_nxt = SCAN;
         end
         SCAN: begin
            cnt_nxt = cnt + 11'd1;
            if (cnt == 11'd2047) state_nxt = DRAIN;
         end
         DRAIN: begin
            cnt_nxt = cnt + 11'd1;
            if (cnt == 11'd1) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Frame parameters and handshake flags, latched when a frame is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel    <= 1'b0;
         scl    <= '0;
         busy   <= 1'b0;
         go_out <= 1'b0;
      end else if (state == IDLE && go_in) begin
         sel    <= cur_buf;
         scl    <= scale;
         busy   <= 1'b1;
         go_out <= 1'b0;
      end else if (state == DONE) begin
         busy   <= 1'b0;
         go_out <= 1'b1;
      end
   end

   // Two-stage remap pipeline; phase product is signed x unsigned, wrapping mod 2^16.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld   <= 1'b0;
         rd_k     <= '0;
         wr_vld   <= 1'b0;
         wr_j     <= '0;
         wr_mag   <= '0;
         wr_phase <= '0;
      end else begin
         rd_vld   <= (state == SCAN);
         rd_k     <= cnt;
         wr_vld   <= rd_vld;
         wr_j     <= 15'(({12'd0, rd_k} * {11'd0, scl}) >> 8);
         wr_mag   <= rd_mag;
         wr_phase <= 16'(({{13{rd_phase[15]}}, rd_phase} * {17'd0, scl}) >> 8);
      end
   end

   // Read addresses go only to the selected buffer during SCAN; writes come from CLEAR or the pipeline.
   always_comb begin
      mag_buf_0_addr   = '0;
      phase_buf_0_addr = '0;
      mag_buf_1_addr   = '0;
      phase_buf_1_addr = '0;
      out_mag_addr     = '0;
      out_mag_data     = '0;
      out_mag_wren     = 1'b0;
      out_phase_addr   = '0;
      out_phase_data   = '0;
      out_phase_wren   = 1'b0;
      if (state == SCAN) begin
         if (sel) begin
            mag_buf_1_addr   = {1'b0, cnt};
            phase_buf_1_addr = {1'b0, cnt};
         end else begin
            mag_buf_0_addr   = {1'b0, cnt};
            phase_buf_0_addr = {1'b0, cnt};
         end
      end
      if (state == CLEAR) begin
         out_mag_addr   = {1'b0, cnt};
         out_phase_addr = {1'b0, cnt};
         out_mag_wren   = 1'b1;
         out_phase_wren = 1'b1;
      end else if (scan_wren) begin
         out_mag_addr   = wr_j[11:0];
         out_phase_addr = wr_j[11:0];
         out_mag_data   = wr_mag;
         out_phase_data = wr_phase;
         out_mag_wren   = 1'b1;
         out_phase_wren = 1'b1;
      end
   end

endmodule

// File: tb/tb_spectral_scaler.sv
// Testbench for spectral_scaler: bench-side RAMs, a cycle-level frame model
// checked every cycle, and whole-spectrum comparisons after each frame.
module tb_spectral_scaler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        go_in = 1'b0;
   logic        cur_buf = 1'b0;
   logic [11:0] scale = 12'h100;
   logic [11:0] mag_buf_0_addr, phase_buf_0_addr, mag_buf_1_addr, phase_buf_1_addr;
   logic [15:0] mag_buf_0_data, phase_buf_0_data, mag_buf_1_data, phase_buf_1_data;
   logic [11:0] out_mag_addr, out_phase_addr;
   logic [15:0] out_mag_data, out_phase_data;
   logic        out_mag_wren, out_phase_wren, busy, go_out;

   logic [15:0] mag0 [0:2047];
   logic [15:0] ph0  [0:2047];
   logic [15:0] mag1 [0:2047];
   logic [15:0] ph1  [0:2047];
   logic [15:0] outMag [0:2047];
   logic [15:0] outPh  [0:2047];
   logic [15:0] expMag [0:2047];
   logic [15:0] expPh  [0:2047];

   int checksTotal = 0;
   int checksPassed = 0;

   // Frame model state: cycles since the accepted go_in and latched parameters.
   logic        mActive = 1'b0;
   logic        mGoOut = 1'b0;
   int          mN = 0;
   logic        mSel = 1'b0;
   logic [11:0] mScl = '0;

   int           cmpK, cmpJ;
   logic [15:0]  cmpMag, cmpPh;
   logic [1:0]   expStatus, expWr;
   logic [47:0]  expRd;
   logic [55:0]  expWd;

   spectral_scaler dut (
      .clk(clk), .rst_n(rst_n), .go_in(go_in), .cur_buf(cur_buf), .scale(scale),
      .mag_buf_0_addr(mag_buf_0_addr), .mag_buf_0_data(mag_buf_0_data),
      .phase_buf_0_addr(phase_buf_0_addr), .phase_buf_0_data(phase_buf_0_data),
      .mag_buf_1_addr(mag_buf_1_addr), .mag_buf_1_data(mag_buf_1_data),
      .phase_buf_1_addr(phase_buf_1_addr), .phase_buf_1_data(phase_buf_1_data),
      .out_mag_addr(out_mag_addr), .out_mag_data(out_mag_data), .out_mag_wren(out_mag_wren),
      .out_phase_addr(out_phase_addr), .out_phase_data(out_phase_data), .out_phase_wren(out_phase_wren),
      .busy(busy), .go_out(go_out)
   );

   always #5 clk = ~clk;

   // Signed phase times unsigned Q4.8 factor, keeping bits [23:8] of the product.
   function automatic logic [15:0] phaseScale(input logic [15:0] ph, input logic [11:0] s);
      longint prod;
      prod = longint'($signed(ph)) * longint'(s);
      return prod[23:8];
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checksTotal++;
      if (act === exp) checksPassed++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // One-cycle-latency read RAMs for both ping-pong buffers.
   always @(posedge clk) begin
      mag_buf_0_data   <= mag0[mag_buf_0_addr[10:0]];
      phase_buf_0_data <= ph0[phase_buf_0_addr[10:0]];
      mag_buf_1_data   <= mag1[mag_buf_1_addr[10:0]];
      phase_buf_1_data <= ph1[phase_buf_1_addr[10:0]];
   end

   // Output spectrum RAMs written by the DUT.
   always @(posedge clk) begin
      if (out_mag_wren) outMag[out_mag_addr[10:0]] <= out_mag_data;
      if (out_phase_wren) outPh[out_phase_addr[10:0]] <= out_phase_data;
   end

   // Frame timeline model: a frame accepted at edge A runs through cycle A+4098.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mActive <= 1'b0;
         mGoOut  <= 1'b0;
         mN      <= 0;
      end else if (!mActive) begin
         if (go_in) begin
            mActive <= 1'b1;
            mN      <= 0;
            mSel    <= cur_buf;
            mScl    <= scale;
            mGoOut  <= 1'b0;
         end
      end else if (mN == 4098) begin
         mActive <= 1'b0;
         mGoOut  <= 1'b1;
      end else begin
         mN <= mN + 1;
      end
   end

   // Per-cycle compare: clear writes in cycles 0..2047, reads 2048..4095, remapped writes 2050..4097.
   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("resetOutputs",
            {20'd0, mag_buf_0_addr, phase_buf_0_addr, mag_buf_1_addr, phase_buf_1_addr,
             out_mag_addr, out_mag_data, out_phase_addr, out_phase_data,
             out_mag_wren, out_phase_wren, busy, go_out}, 128'd0);
      end else begin
         expStatus = {mActive, mGoOut};
         expRd = '0;
         expWr = 2'b00;
         expWd = '0;
         if (mActive && mN >= 2048 && mN <= 4095) begin
            if (mSel) expRd[23:0] = {12'(mN - 2048), 12'(mN - 2048)};
            else      expRd[47:24] = {12'(mN - 2048), 12'(mN - 2048)};
         end
         if (mActive && mN <= 2047) begin
            expWr = 2'b11;
            expWd = {12'(mN), 16'h0000, 12'(mN), 16'h0000};
         end else if (mActive && mN >= 2050 && mN <= 4097) begin
            cmpK = mN - 2050;
            cmpJ = (cmpK * int'(mScl)) >> 8;
            cmpMag = mSel ? mag1[cmpK] : mag0[cmpK];
            cmpPh = phaseScale(mSel ? ph1[cmpK] : ph0[cmpK], mScl);
            if (cmpJ <= 2047) begin
               expWr = 2'b11;
               expWd = {12'(cmpJ), cmpMag, 12'(cmpJ), cmpPh};
            end
         end
         checkOutput("status", {126'd0, busy, go_out}, {126'd0, expStatus});
         checkOutput("readAddr",
            {80'd0, mag_buf_0_addr, phase_buf_0_addr, mag_buf_1_addr, phase_buf_1_addr},
            {80'd0, expRd});
         checkOutput("wren", {126'd0, out_mag_wren, out_phase_wren}, {126'd0, expWr});
         if (expWr == 2'b11)
            checkOutput("writeData",
               {72'd0, out_mag_addr, out_mag_data, out_phase_addr, out_phase_data},
               {72'd0, expWd});
      end
   end

   // Final spectrum after a frame: cleared, then bins written in ascending k so later k wins.
   task automatic checkFrame(input logic selIn, input logic [11:0] scaleIn);
      int j;
      int bad;
      for (int i = 0; i < 2048; i++) begin
         expMag[i] = 16'h0000;
         expPh[i]  = 16'h0000;
      end
      for (int k = 0; k < 2048; k++) begin
         j = (k * int'(scaleIn)) >> 8;
         if (j <= 2047) begin
            expMag[j] = selIn ? mag1[k] : mag0[k];
            expPh[j]  = phaseScale(selIn ? ph1[k] : ph0[k], scaleIn);
         end
      end
      bad = 0;
      for (int i = 0; i < 2048; i++)
         if (outMag[i] !== expMag[i] || outPh[i] !== expPh[i]) bad++;
      checkOutput("frameSpectrumBadBins", 128'(bad), 128'd0);
   endtask

   // Runs one frame; optionally re-pulses go_in with a different scale reGoAt cycles in.
   task automatic applyStimulus(input logic selIn, input logic [11:0] scaleIn,
                                input int reGoAt, input logic [11:0] reScale);
      int waited;
      @(posedge clk); #2;
      cur_buf = selIn;
      scale   = scaleIn;
      go_in   = 1'b1;
      @(posedge clk); #2;
      go_in = 1'b0;
      if (reGoAt > 0) begin
         repeat (reGoAt - 1) @(posedge clk);
         #2;
         go_in = 1'b1;
         scale = reScale;
         cur_buf = ~selIn;
         @(posedge clk); #2;
         go_in = 1'b0;
      end
      waited = 0;
      while (!go_out && waited < 5000) begin
         @(posedge clk); #2;
         waited++;
      end
      checkOutput("frameDone", {127'd0, go_out}, 128'd1);
      @(posedge clk); #2;
      checkFrame(selIn, scaleIn);
      scale = scaleIn;
      cur_buf = selIn;
   endtask

   initial begin
      for (int k = 0; k < 2048; k++) begin
         mag0[k] = 16'(k);
         ph0[k]  = 16'(16'h0100 + k);
         mag1[k] = 16'(k * 7 + 3);
         ph1[k]  = 16'(k * 97);
      end
      ph1[10] = 16'h7FFF;
      ph1[11] = 16'h8000;

      #1 rst_n = 1'b0;
      #1;
      checkOutput("resetState",
         {22'd0, out_mag_wren, out_phase_wren, busy, go_out, out_mag_addr, out_phase_addr,
          mag_buf_0_addr, mag_buf_1_addr}, 128'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("[TB] identity frame");
      applyStimulus(1'b0, 12'h100, 0, 12'h000);
      checkOutput("identMag5", 128'(outMag[5]), 128'd5);
      checkOutput("identPh5", 128'(outPh[5]), 128'h105);
      checkOutput("identPh2047", 128'(outPh[2047]), 128'h8FF);

      $display("[TB] octave-up frame");
      applyStimulus(1'b1, 12'h200, 0, 12'h000);
      checkOutput("octMag10", 128'(outMag[10]), 128'd38);
      checkOutput("octMagOdd21", 128'(outMag[21]), 128'd0);
      checkOutput("octPhWrap7FFF", 128'(outPh[20]), 128'hFFFE);
      checkOutput("octPhWrap8000", 128'(outPh[22]), 128'h0000);

      $display("[TB] fractional frame");
      applyStimulus(1'b0, 12'h080, 0, 12'h000);
      checkOutput("fracMag3", 128'(outMag[3]), 128'd7);
      checkOutput("fracMag1023", 128'(outMag[1023]), 128'd2047);
      checkOutput("fracMag1024", 128'(outMag[1024]), 128'd0);
      checkOutput("fracPh3", 128'(outPh[3]), 128'h83);

      $display("[TB] busy-ignore frame");
      applyStimulus(1'b0, 12'h100, 100, 12'h200);
      checkOutput("ignoreMag1500", 128'(outMag[1500]), 128'd1500);

      $display("[TB] mid-frame reset");
      @(posedge clk); #2;
      cur_buf = 1'b1;
      scale   = 12'h200;
      go_in   = 1'b1;
      @(posedge clk); #2;
      go_in = 1'b0;
      repeat (3000) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("midResetOutputs",
         {22'd0, out_mag_wren, out_phase_wren, busy, go_out, out_mag_addr, out_phase_addr,
          mag_buf_0_addr, mag_buf_1_addr}, 128'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      applyStimulus(1'b0, 12'h100, 0, 12'h000);
      checkOutput("postResetMag2000", 128'(outMag[2000]), 128'd2000);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
